// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port round-robin arbiter and sequencer in front of a single-port
//   data memory. Port m0 (CPU load/store) and port m1 (loader/debug) each
//   issue one word read or write at a time. The winner's command is latched.
//   The memory strobe is held for the required number of cycles, read data is
//   captured, and a one-cycle ack is returned to the winner.
//
// Parameters
//   DATA_W   data word width
//   ADDR_W   memory address width
//   MEM_LAT  cycles mem_read is held before mem_data_out is valid (1..3)
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   mN_req/we/addr/wdata        request, direction, address and write data from port N
//   mN_ack                      one-cycle completion pulse to port N
//   mN_rdata                    last read data for port N, held between reads
//   mem_address/mem_data_in     address and write data to the memory
//   mem_write/mem_read          memory strobes, never both high
//   mem_data_out                read data from the memory
//   busy                        high whenever the sequencer is not idle
module dmem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  // Value of lat_cnt during the final cycle of a read strobe.
  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;  // 0 = m0, 1 = m1
  logic                grant_q, grant_d;            // current winner
  logic                we_q, we_d;
  logic [1:0]          lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                busy_q, busy_d;
  logic                win;
  logic                win_we;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    we_d          = we_q;
    lat_cnt_d     = lat_cnt_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    mem_write_d   = mem_write_q;
    mem_read_d    = mem_read_q;
    m0_ack_d      = 1'b0;
    m1_ack_d      = 1'b0;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    win           = 1'b0;
    win_we        = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // A lone requester wins outright; on contention the port that
          // did not win last time goes first, so neither side can starve.
          win           = (m0_req && m1_req) ? ~last_grant_q : m1_req;
          win_we        = win ? m1_we : m0_we;
          grant_d       = win;
          last_grant_d  = win;
          we_d          = win_we;
          mem_address_d = win ? m1_addr : m0_addr;
          mem_data_in_d = win ? m1_wdata : m0_wdata;
          mem_write_d   = win_we;
          mem_read_d    = ~win_we;
          lat_cnt_d     = 2'd0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          mem_write_d = 1'b0;
          m0_ack_d    = ~grant_q;
          m1_ack_d    = grant_q;
          state_d     = DONE;
        end else if (lat_cnt_q == LAT_LAST) begin
          // Last strobe cycle: memory output is valid now.
          mem_read_d = 1'b0;
          if (grant_q) m1_rdata_d = mem_data_out;
          else         m0_rdata_d = mem_data_out;
          m0_ack_d   = ~grant_q;
          m1_ack_d   = grant_q;
          state_d    = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      we_q          <= 1'b0;
      lat_cnt_q     <= 2'd0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      we_q          <= we_d;
      lat_cnt_q     <= lat_cnt_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      m0_ack_q      <= m0_ack_d;
      m1_ack_q      <= m1_ack_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
      busy_q        <= busy_d;
    end
  end

  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Drives two arbiter instances (MEM_LAT=1 and MEM_LAT=3), each in front of
//   a behavioural memory whose output is only valid in the last cycle of the
//   read strobe. Requesters push the expected ack cycle and read data into
//   per-port queues; a monitor pops and compares on every ack.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [2];
  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          ack   [2][2];
  logic [DW-1:0] rdata [2][2];
  logic [AW-1:0] mem_address  [2];
  logic [DW-1:0] mem_data_in  [2];
  logic          mem_write    [2];
  logic          mem_read     [2];
  logic [DW-1:0] mem_data_out [2];
  logic          busy         [2];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] mem [16];
    int rd_cnt = 0;
    always @(posedge clk) begin
      if (mem_write[g]) mem[mem_address[g]] <= mem_data_in[g];
      rd_cnt <= mem_read[g] ? rd_cnt + 1 : 0;
    end
    assign mem_data_out[g] = (mem_read[g] && rd_cnt == LAT - 1) ? mem[mem_address[g]] : 32'hDEAD_BEEF;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .reset(rst[g]),
      .m0_req(req[g][0]), .m0_we(we[g][0]), .m0_addr(addr[g][0]), .m0_wdata(wdata[g][0]),
      .m0_ack(ack[g][0]), .m0_rdata(rdata[g][0]),
      .m1_req(req[g][1]), .m1_we(we[g][1]), .m1_addr(addr[g][1]), .m1_wdata(wdata[g][1]),
      .m1_ack(ack[g][1]), .m1_rdata(rdata[g][1]),
      .mem_address(mem_address[g]), .mem_data_in(mem_data_in[g]),
      .mem_write(mem_write[g]), .mem_read(mem_read[g]),
      .mem_data_out(mem_data_out[g]), .busy(busy[g])
    );
  end

  typedef struct {
    logic          is_read;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t q [4][$];   // index dut*2 + port
  exp_t mon_e;

  // Monitor: exclusivity every cycle, scoreboard pop on every ack.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ((ack[d][0] && ack[d][1]) || (mem_write[d] && mem_read[d])) begin
        n_fail++;
        $display("FAIL excl dut%0d cycle %0d: ack=%b%b wr/rd=%b%b, required at most one of each high",
                 d, cyc, ack[d][0], ack[d][1], mem_write[d], mem_read[d]);
      end
      for (int p = 0; p < 2; p++) begin
        if (ack[d][p]) begin
          n_chk++;
          if (q[d*2+p].size() == 0) begin
            n_fail++;
            $display("FAIL ack_unexpected dut%0d m%0d: ack at cycle %0d, required no ack", d, p, cyc);
          end else begin
            mon_e = q[d*2+p].pop_front();
            if (cyc != mon_e.cyc || (mon_e.is_read && rdata[d][p] !== mon_e.rdata)) begin
              n_fail++;
              $display("FAIL ack dut%0d m%0d: cycle %0d rdata %h, required cycle %0d rdata %h",
                       d, p, cyc, rdata[d][p], mon_e.cyc, mon_e.rdata);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; lat is the expected ack cycle offset
  // from this launch cycle.
  task automatic xact(input int d, input int p, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input int lat, input logic [DW-1:0] exp_rd);
    exp_t e;
    bit got;
    e.is_read = !w;
    e.rdata   = exp_rd;
    e.cyc     = cyc + lat;
    q[d*2+p].push_back(e);
    req[d][p]   = 1'b1;
    we[d][p]    = w;
    addr[d][p]  = a;
    wdata[d][p] = wd;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = ack[d][p];
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout dut%0d m%0d: no ack by cycle %0d, required ack at cycle %0d", d, p, cyc, e.cyc);
    end
    @(posedge clk);
    #1;
    req[d][p] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
      end
    end
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_mem_write%0d", d), mem_write[d], 0);
      chk($sformatf("rst_mem_read%0d", d), mem_read[d], 0);
      chk($sformatf("rst_busy%0d", d), busy[d], 0);
      chk($sformatf("rst_acks%0d", d), {ack[d][0], ack[d][1]}, 0);
      chk($sformatf("rst_rdata0_%0d", d), rdata[d][0], 0);
      chk($sformatf("rst_rdata1_%0d", d), rdata[d][1], 0);
      chk($sformatf("rst_addr%0d", d), mem_address[d], 0);
      chk($sformatf("rst_din%0d", d), mem_data_in[d], 0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // m0 write 0x55555555 @0
    fork
      xact(0, 0, 1'b1, 4'd0, 32'h5555_5555, 2, '0);
      begin
        @(negedge clk);
        chk("t1_c0_write", mem_write[0], 0);
        chk("t1_c0_busy", busy[0], 0);
        @(negedge clk);
        chk("t1_c1_write", mem_write[0], 1);
        chk("t1_c1_addr", mem_address[0], 0);
        chk("t1_c1_din", mem_data_in[0], 32'h5555_5555);
        chk("t1_c1_busy", busy[0], 1);
        @(negedge clk);
        chk("t1_c2_write", mem_write[0], 0);
      end
    join

    // m0 read @0
    fork
      xact(0, 0, 1'b0, 4'd0, '0, 2, 32'h5555_5555);
      begin
        repeat (2) @(negedge clk);
        chk("t2_c1_read", mem_read[0], 1);
        chk("t2_c1_write", mem_write[0], 0);
        @(negedge clk);
        chk("t2_c2_read", mem_read[0], 0);
      end
    join
    chk("t2_m1_rdata", rdata[0][1], 0);
    tick(2);
    chk("t2_m0_rdata_held", rdata[0][0], 32'h5555_5555);

    // Simultaneous writes right after reset: m0 first, m1 three cycles later
    rst[0] = 1'b1;
    tick(2);
    rst[0] = 1'b0;
    chk("t3_rst_rdata", rdata[0][0], 0);
    fork
      xact(0, 0, 1'b1, 4'd1,  32'hAAAA_AAAA, 2, '0);
      xact(0, 1, 1'b1, 4'd15, 32'h5555_5555, 5, '0);
    join
    xact(0, 0, 1'b0, 4'd1,  '0, 2, 32'hAAAA_AAAA);
    xact(0, 1, 1'b0, 4'd15, '0, 2, 32'h5555_5555);
    chk("t3_m0_rdata_kept", rdata[0][0], 32'hAAAA_AAAA);

    // Both ports requesting continuously: strict alternation, m0 first
    fork
      for (int k = 0; k < 3; k++) xact(0, 0, 1'b1, 4'(2 + k), 32'h1000 + k, (k == 0) ? 2 : 5, '0);
      for (int k = 0; k < 3; k++) xact(0, 1, 1'b1, 4'(5 + k), 32'h2000 + k, 5, '0);
    join
    xact(0, 1, 1'b0, 4'd4, '0, 2, 32'h0000_1002);
    xact(0, 0, 1'b0, 4'd7, '0, 2, 32'h0000_2002);

    // MEM_LAT=3: m1 write then read @15
    xact(1, 1, 1'b1, 4'd15, 32'h1234_5678, 2, '0);
    fork
      xact(1, 1, 1'b0, 4'd15, '0, 4, 32'h1234_5678);
      begin
        repeat (2) @(negedge clk);
        chk("t5_c1_read", mem_read[1], 1);
        @(negedge clk);
        chk("t5_c2_read", mem_read[1], 1);
        @(negedge clk);
        chk("t5_c3_read", mem_read[1], 1);
        @(negedge clk);
        chk("t5_c4_read", mem_read[1], 0);
      end
    join

    // MEM_LAT=3: reset in the second read cycle drops the transaction
    req[1][0]  = 1'b1;
    we[1][0]   = 1'b0;
    addr[1][0] = 4'd15;
    tick(1);
    chk("t6_c1_read", mem_read[1], 1);
    tick(1);
    chk("t6_c2_read", mem_read[1], 1);
    rst[1]    = 1'b1;
    req[1][0] = 1'b0;
    tick(1);
    chk("t6_read_dropped", mem_read[1], 0);
    chk("t6_busy", busy[1], 0);
    chk("t6_ack", {ack[1][0], ack[1][1]}, 0);
    chk("t6_m0_rdata", rdata[1][0], 0);
    chk("t6_m1_rdata", rdata[1][1], 0);
    rst[1] = 1'b0;
    tick(4);
    chk("t6_idle_after", busy[1], 0);
    xact(1, 0, 1'b0, 4'd15, '0, 4, 32'h1234_5678);

    tick(3);
    for (int i = 0; i < 4; i++) chk($sformatf("queue_empty%0d", i), q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
